// File: rtl/mac_pkg.sv
// Shared definitions for the MAC-array output memory (OMem).
// Holds the tile geometry, the drain FSM state type, the MNT legality check
// and the element-to-word address map. The array controller (writer side)
// and omem_drain (reader side) both use omem_addr() so the layout cannot drift.
package mac_pkg;

  localparam int TILE       = 4;   // lanes per OMem word
  localparam int MAX_DIM    = 8;   // largest M, N or T
  localparam int OMEM_DEPTH = 16;  // words in OMem

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LD,
    S_EMIT,
    S_CLR,
    S_FIN
  } drain_state_t;

  // One dimension is legal when it is in 1..MAX_DIM.
  function automatic logic dim_ok(input logic [3:0] d);
    return (d != 4'd0) && (d <= 4'(MAX_DIM));
  endfunction

  // MNT = {M, N, T}; all three must be legal even though only M and T
  // shape the drain.
  function automatic logic mnt_legal(input logic [11:0] mnt);
    return dim_ok(mnt[11:8]) && dim_ok(mnt[7:4]) && dim_ok(mnt[3:0]);
  endfunction

  // Element (r,c) lives in word {r[2], c[2], r[1:0]}, lane c[1:0]:
  // each 4x4 tile occupies four consecutive words, one per row.
  function automatic logic [3:0] omem_addr(input logic [2:0] r, input logic [2:0] c);
    return {r[2], c[2], r[1:0]};
  endfunction

endpackage

// File: rtl/omem_addr_gen.sv
// Row/column walker for the OMem drain.
// Ports:
//   CLK, RSTN      clock, asynchronous active-low reset
//   init           restart at element (0,0)
//   advance        step to the next element in row-major order
//   m_last,t_last  M-1 and T-1 as 3-bit values
//   addr, lane     OMem word and lane of the current element
//   word_end       current element is the last one needed from its word
//   last           current element is (M-1, T-1)
module omem_addr_gen
  import mac_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       init,
  input  logic       advance,
  input  logic [2:0] m_last,
  input  logic [2:0] t_last,
  output logic [3:0] addr,
  output logic [1:0] lane,
  output logic       word_end,
  output logic       last
);

  logic [2:0] row;
  logic [2:0] col;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      row <= '0;
      col <= '0;
    end else if (init) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == t_last) begin
        col <= '0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

  assign addr     = omem_addr(row, col);
  assign lane     = col[1:0];
  // A word runs out at lane 3, or earlier when the row ends inside it.
  assign word_end = (col == t_last) || (col[1:0] == 2'd3);
  assign last     = (row == m_last) && (col == t_last);

endmodule

// File: rtl/omem_drain.sv
// Reader side of the MAC-array output memory.
// Streams the M x T result matrix out of OMem in row-major order, one element
// per valid/ready handshake, and optionally zeroes each word once drained.
// Ports:
//   CLK, RSTN              clock, asynchronous active-low reset
//   Start, MNT             start pulse and {M,N,T} sampled with it
//   ORdEn, ORdAddr         OMem read request; ORdData returns one cycle later
//   OClrEn, OClrAddr       OMem write-zero strobe (CLR_ON_READ=1 only)
//   OutData/Valid/Ready    element stream; OutLast marks (M-1,T-1)
//   Busy, Done, Err        status; Done pulses at the end, Err with it on illegal MNT
module omem_drain
  import mac_pkg::*;
#(
  parameter int DW          = 16,
  parameter int CLR_ON_READ = 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               Start,
  input  logic [11:0]        MNT,
  output logic               ORdEn,
  output logic [3:0]         ORdAddr,
  input  logic [TILE*DW-1:0] ORdData,
  output logic               OClrEn,
  output logic [3:0]         OClrAddr,
  output logic [DW-1:0]      OutData,
  output logic               OutValid,
  input  logic               OutReady,
  output logic               OutLast,
  output logic               Busy,
  output logic               Done,
  output logic               Err
);

  drain_state_t state, state_nxt;

  logic [2:0]    m_last, t_last;
  logic          err_q;
  logic          last_q;      // the word just drained held the final element
  logic [3:0]    clr_addr_q;  // counters have moved on by the CLR cycle
  logic [DW-1:0] word_buf [TILE];

  logic [3:0] addr;
  logic [1:0] lane;
  logic       word_end, last;
  logic       start_ok, hs;

  assign start_ok = (state == S_IDLE) && Start && mnt_legal(MNT);
  assign hs       = (state == S_EMIT) && OutReady;

  omem_addr_gen u_addr_gen (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .init     (start_ok),
    .advance  (hs),
    .m_last   (m_last),
    .t_last   (t_last),
    .addr     (addr),
    .lane     (lane),
    .word_end (word_end),
    .last     (last)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= S_IDLE;
      m_last     <= '0;
      t_last     <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      state <= state_nxt;
      // MNT is only looked at in IDLE, so a Start while busy is ignored.
      if (state == S_IDLE && Start) begin
        err_q  <= !mnt_legal(MNT);
        m_last <= 3'(MNT[11:8] - 4'd1);
        t_last <= 3'(MNT[3:0] - 4'd1);
      end
      if (hs && word_end) begin
        clr_addr_q <= addr;
        last_q     <= last;
      end
    end
  end

  // NOTE: the word buffer is only four registers, so it is reset like any
  // other flop; a large RAM-style array would be left without reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int k = 0; k < TILE; k++) word_buf[k] <= '0;
    end else if (state == S_LD) begin
      for (int k = 0; k < TILE; k++) word_buf[k] <= ORdData[k*DW +: DW];
    end
  end

  // NOTE: every signal driven here gets a default first, which keeps the
  // block free of inferred latches whatever path the case takes.
  always_comb begin
    state_nxt = state;
    ORdEn     = 1'b0;
    ORdAddr   = '0;
    OClrEn    = 1'b0;
    OClrAddr  = '0;
    OutValid  = 1'b0;
    OutData   = '0;
    OutLast   = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    Err       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) state_nxt = mnt_legal(MNT) ? S_RD : S_FIN;
      end
      S_RD: begin
        Busy      = 1'b1;
        ORdEn     = 1'b1;
        ORdAddr   = addr;
        state_nxt = S_LD;
      end
      S_LD: begin
        Busy      = 1'b1;
        state_nxt = S_EMIT;
      end
      S_EMIT: begin
        Busy     = 1'b1;
        OutValid = 1'b1;
        OutData  = word_buf[lane];
        OutLast  = last;
        if (OutReady && word_end) begin
          if (CLR_ON_READ != 0) state_nxt = S_CLR;
          else                  state_nxt = last ? S_FIN : S_RD;
        end
      end
      S_CLR: begin
        Busy      = 1'b1;
        OClrEn    = (CLR_ON_READ != 0);
        OClrAddr  = clr_addr_q;
        state_nxt = last_q ? S_FIN : S_RD;
      end
      S_FIN: begin
        Done      = 1'b1;
        Err       = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_omem_drain.sv
module tb_omem_drain;

  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          start, start2;
  logic [11:0]   mnt, mnt2;
  logic          ord_en, ord_en2;
  logic [3:0]    ord_addr, ord_addr2;
  logic [63:0]   rd_data, rd_data2;
  logic          oclr_en, oclr_en2;
  logic [3:0]    oclr_addr, oclr_addr2;
  logic [DW-1:0] out_data, out_data2;
  logic          out_valid, out_valid2;
  logic          out_ready;
  logic          out_ready2 = 1'b1;
  logic          out_last, out_last2;
  logic          busy, busy2, done, done2, err, err2;

  always #5 CLK = ~CLK;

  omem_drain #(.DW(DW), .CLR_ON_READ(1)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .Start(start), .MNT(mnt),
    .ORdEn(ord_en), .ORdAddr(ord_addr), .ORdData(rd_data),
    .OClrEn(oclr_en), .OClrAddr(oclr_addr),
    .OutData(out_data), .OutValid(out_valid), .OutReady(out_ready), .OutLast(out_last),
    .Busy(busy), .Done(done), .Err(err)
  );

  omem_drain #(.DW(DW), .CLR_ON_READ(0)) u_dut_noclr (
    .CLK(CLK), .RSTN(RSTN), .Start(start2), .MNT(mnt2),
    .ORdEn(ord_en2), .ORdAddr(ord_addr2), .ORdData(rd_data2),
    .OClrEn(oclr_en2), .OClrAddr(oclr_addr2),
    .OutData(out_data2), .OutValid(out_valid2), .OutReady(out_ready2), .OutLast(out_last2),
    .Busy(busy2), .Done(done2), .Err(err2)
  );

  // ---------------- OMem model ----------------
  logic [63:0] mem [16];
  logic        fill_go = 1'b0;
  int          fill_mode = 0;

  // Pattern: word a, lane k holds a*16+k; mode 1 overrides word 0 lane 0.
  always @(posedge CLK) begin
    if (ord_en)  rd_data  <= mem[ord_addr];
    if (ord_en2) rd_data2 <= mem[ord_addr2];
    if (fill_go) begin
      for (int a = 0; a < 16; a++)
        for (int k = 0; k < 4; k++) mem[a][k*16 +: 16] <= 16'(a*16 + k);
      if (fill_mode == 1) mem[0][15:0] <= 16'h1234;
    end else if (oclr_en) begin
      mem[oclr_addr] <= '0;
    end
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int beats, s_cyc, first_rd, first_val, done_cyc, n_stall;
  bit done_seen, err_seen, stall_prev;
  logic [DW-1:0] stall_data;
  int beats2, hs2_cyc, done2_cyc;
  bit done2_seen, clr2_seen;
  logic [DW-1:0] last_data2;

  logic [DW-1:0] exp_data [$];
  bit            exp_last [$];
  logic [3:0]    exp_rd   [$];
  logic [3:0]    exp_clr  [$];

  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor for the clearing instance: scoreboard pops on each event.
  always @(negedge CLK) begin
    if (!RSTN) begin
      stall_prev = 1'b0;
    end else begin
      if (ord_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (exp_rd.size() == 0) check("rd_extra", exp_rd.size(), 1);
        else check("rd_addr", ord_addr, exp_rd.pop_front());
      end
      if (oclr_en) begin
        if (exp_clr.size() == 0) check("clr_extra", exp_clr.size(), 1);
        else check("clr_addr", oclr_addr, exp_clr.pop_front());
      end
      if (stall_prev) begin
        n_stall++;
        check("stall_hold", out_data, stall_data);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && first_val < 0) first_val = cyc;
      if (out_valid && out_ready) begin
        beats++;
        if (exp_data.size() == 0) check("beat_extra", exp_data.size(), 1);
        else begin
          check("beat_data", out_data, exp_data.pop_front());
          check("beat_last", out_last, exp_last.pop_front());
        end
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        err_seen  = err;
      end
    end
  end

  // Monitor for the non-clearing instance.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (out_valid2) begin
        beats2++;
        hs2_cyc    = cyc;
        last_data2 = out_data2;
      end
      if (oclr_en2) clr2_seen = 1'b1;
      if (done2) begin
        done2_seen = 1'b1;
        done2_cyc  = cyc;
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic int bench_addr(input int r, input int c);
    return (r / 4) * 8 + (c / 4) * 4 + (r % 4);
  endfunction

  task automatic fill(input int mode);
    @(posedge CLK); #1;
    fill_mode = mode;
    fill_go   = 1'b1;
    @(posedge CLK); #1;
    fill_go   = 1'b0;
  endtask

  task automatic push_expect(input int m, input int t);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < t; c++) begin
        int a;
        a = bench_addr(r, c);
        exp_data.push_back(mem[a][(c % 4)*16 +: 16]);
        exp_last.push_back(r == m-1 && c == t-1);
        if (c == t-1 || c % 4 == 3) begin
          exp_rd.push_back(4'(a));
          exp_clr.push_back(4'(a));
        end
      end
  endtask

  task automatic clear_run_state();
    beats = 0; first_rd = -1; first_val = -1; n_stall = 0;
    done_seen = 1'b0; err_seen = 1'b0; done_cyc = -1;
  endtask

  // Start one drain and wait (bounded) for Done; optional stall / mid-run Start.
  task automatic run(input int m, input int n, input int t, input int stall_at, input bit poke);
    bit legal;
    int stall_cnt;
    legal = (m >= 1 && m <= 8 && n >= 1 && n <= 8 && t >= 1 && t <= 8);
    clear_run_state();
    stall_cnt = 0;
    if (legal) push_expect(m, t);
    @(posedge CLK); #1;
    start = 1'b1;
    mnt   = {4'(m), 4'(n), 4'(t)};
    s_cyc = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      @(posedge CLK); #1;
      if (stall_at >= 0 && beats >= stall_at && stall_cnt < 3) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      if (poke && i == 8) begin
        start = 1'b1;
        mnt   = 12'h111;
      end else begin
        start = 1'b0;
      end
    end
    out_ready = 1'b1;
    start     = 1'b0;
    check("done_seen", done_seen, 1);
    check("err_flag", err_seen, legal ? 0 : 1);
    check("beats_left", exp_data.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    check("clr_left", exp_clr.size(), 0);
    if (legal) check("beat_count", beats, m * t);
  endtask

  // ---------------- sequence ----------------
  initial begin
    RSTN = 1'b0; start = 1'b0; start2 = 1'b0; mnt = '0; mnt2 = '0; out_ready = 1'b1;
    clear_run_state();
    beats2 = 0; done2_seen = 1'b0; clr2_seen = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ctrl", {ord_en, oclr_en, out_valid, out_last, busy, done, err}, 0);
    check("rst_data", {out_data, ord_addr, oclr_addr}, 0);
    RSTN = 1'b1;

    // 1: single element, plus first-read / first-valid latency
    fill(1);
    run(1, 1, 1, -1, 0);
    check("lat_rden", first_rd - s_cyc, 1);
    check("lat_valid", first_val - s_cyc, 3);
    check("t1_cleared", mem[0][15:0], 0);

    // 2: full 4x4 tile
    fill(0);
    run(4, 4, 4, -1, 0);
    check("t2_clr0", mem[0], 0);
    check("t2_clr3", mem[3], 0);
    check("t2_keep4", mem[4][15:0], 16'h40);

    // 3: 5x6 spans two tiles horizontally and vertically
    fill(0);
    run(5, 3, 6, -1, 0);

    // 4: three-cycle stall on the sixth beat
    fill(0);
    run(4, 4, 4, 5, 0);
    check("stall_cycles", n_stall, 3);

    // 5: illegal N, then a Start while busy, then the non-clearing variant
    run(8, 0, 8, -1, 0);
    check("illegal_done_lat", done_cyc - s_cyc, 1);
    check("illegal_no_rd", first_rd, -1);
    fill(0);
    run(4, 4, 4, -1, 1);

    fill(0);
    @(posedge CLK); #1;
    start2 = 1'b1; mnt2 = 12'h112;
    @(posedge CLK); #1;
    start2 = 1'b0;
    for (int i = 0; i < 200 && !done2_seen; i++) @(posedge CLK);
    check("nc_done", done2_seen, 1);
    check("nc_beats", beats2, 2);
    check("nc_data", last_data2, 16'h0001);
    check("nc_done_lat", done2_cyc - hs2_cyc, 1);
    check("nc_no_clr", clr2_seen, 0);

    // 6: reset in the middle of an 8x8 drain, then a full drain
    fill(0);
    clear_run_state();
    push_expect(8, 8);
    @(posedge CLK); #1;
    start = 1'b1; mnt = 12'h888;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < 500 && beats < 3; i++) @(posedge CLK);
    check("t6_beats_before_rst", beats, 3);
    @(posedge CLK); #2;
    RSTN = 1'b0;
    #1;
    check("t6_rst_ctrl", {ord_en, oclr_en, out_valid, out_last, busy, done, err}, 0);
    check("t6_rst_data", out_data, 0);
    exp_data.delete(); exp_last.delete(); exp_rd.delete(); exp_clr.delete();
    done_seen = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    check("t6_no_done", done_seen, 0);
    check("t6_idle", busy, 0);
    fill(0);
    run(8, 8, 8, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
